// File: rtl/alu_sequencer.sv
// Issue/writeback stage around a combinational 16-bit ALU: decodes opcodes to a one-hot
// opFlag, holds operands for SETTLE cycles, captures result/flags and presents a writeback beat.
module alu_sequencer #(
  parameter int SETTLE = 1,
  parameter int DST_W  = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       opcode,
  input  logic [15:0]      src_a,
  input  logic [15:0]      src_b,
  input  logic [DST_W-1:0] dst,
  output logic [15:0]      alu_a,
  output logic [15:0]      alu_b,
  output logic [8:0]       alu_op,
  input  logic [15:0]      alu_result,
  input  logic [5:0]       alu_flags,
  output logic             wb_valid,
  input  logic             wb_ready,
  output logic [15:0]      wb_data,
  output logic [DST_W-1:0] wb_dst,
  output logic             wb_we,
  output logic [5:0]       flags_q,
  output logic             illegal
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_WB
  } state_e;

  localparam logic [2:0] CNT_INIT = 3'(SETTLE - 1);
  localparam int         OP_SUB   = 4;
  localparam int         OP_CMP   = 8;

  state_e           state_q, state_d;
  logic [2:0]       cnt_q, cnt_d;
  logic [15:0]      alu_a_q, alu_a_d;
  logic [15:0]      alu_b_q, alu_b_d;
  logic [8:0]       alu_op_q, alu_op_d;
  logic [15:0]      wb_data_q, wb_data_d;
  logic [DST_W-1:0] wb_dst_q, wb_dst_d;
  logic             wb_we_q, wb_we_d;
  logic [5:0]       flags_d;
  logic [5:0]       flags_r;
  logic             illegal_q, illegal_d;
  // Forces one idle beat when an illegal request is taken straight out of WB.
  logic             gap_q, gap_d;

  logic             accept;
  logic             op_legal;
  logic [8:0]       op_onehot;
  logic             unused_flag5;

  assign unused_flag5 = alu_flags[5];

  assign op_legal  = (opcode <= 4'd8);
  assign op_onehot = 9'd1 << opcode;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    state_d   = state_q;
    cnt_d     = cnt_q;
    alu_a_d   = alu_a_q;
    alu_b_d   = alu_b_q;
    alu_op_d  = alu_op_q;
    wb_data_d = wb_data_q;
    wb_dst_d  = wb_dst_q;
    wb_we_d   = wb_we_q;
    flags_d   = flags_r;
    illegal_d = 1'b0;
    gap_d     = 1'b0;
    in_ready  = 1'b0;
    wb_valid  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
      end
      S_EXEC: begin
        if (cnt_q == 3'd0) begin
          wb_data_d = alu_result;
          wb_we_d   = ~alu_op_q[OP_CMP];
          if (alu_op_q[OP_CMP]) begin
            flags_d[1:0] = alu_flags[1:0];
          end else if (alu_op_q[OP_SUB]) begin
            flags_d[4:2] = alu_flags[4:2];
          end else begin
            flags_d[4] = alu_flags[4];
            flags_d[2] = alu_flags[2];
          end
          state_d = S_WB;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      S_WB: begin
        wb_valid = ~gap_q;
        in_ready = wb_ready & ~gap_q;
        if (!gap_q && wb_ready && !in_valid) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    accept = in_valid & in_ready;
    if (accept) begin
      wb_dst_d = dst;
      if (op_legal) begin
        alu_a_d  = src_a;
        alu_b_d  = src_b;
        alu_op_d = op_onehot;
        cnt_d    = CNT_INIT;
        state_d  = S_EXEC;
      end else begin
        illegal_d = 1'b1;
        wb_data_d = 16'h0000;
        wb_we_d   = 1'b0;
        gap_d     = (state_q == S_WB);
        state_d   = S_WB;
      end
    end

    flags_d[5] = 1'b0;
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= 3'd0;
      alu_a_q   <= 16'h0000;
      alu_b_q   <= 16'h0000;
      alu_op_q  <= 9'b000000001;
      wb_data_q <= 16'h0000;
      wb_dst_q  <= '0;
      wb_we_q   <= 1'b0;
      flags_r   <= 6'b000000;
      illegal_q <= 1'b0;
      gap_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      alu_a_q   <= alu_a_d;
      alu_b_q   <= alu_b_d;
      alu_op_q  <= alu_op_d;
      wb_data_q <= wb_data_d;
      wb_dst_q  <= wb_dst_d;
      wb_we_q   <= wb_we_d;
      flags_r   <= flags_d;
      illegal_q <= illegal_d;
      gap_q     <= gap_d;
    end
  end

  assign alu_a   = alu_a_q;
  assign alu_b   = alu_b_q;
  assign alu_op  = alu_op_q;
  assign wb_data = wb_data_q;
  assign wb_dst  = wb_dst_q;
  assign wb_we   = wb_we_q;
  assign flags_q = flags_r;
  assign illegal = illegal_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer: one SETTLE=1 instance for the functional vectors and
// one SETTLE=3 instance for settle latency and mid-EXEC reset.
module tb_alu_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference ALU: flags {0, OF, SF, ZF, BG, EQ}.
  function automatic logic [21:0] alu_model(input logic [15:0] a, input logic [15:0] b,
                                            input logic [8:0] op);
    logic [15:0] r;
    logic        of;
    r  = 16'h0000;
    of = 1'b0;
    if (op[0])      r = ~a;
    else if (op[1]) r = a | b;
    else if (op[2]) r = a & b;
    else if (op[3]) begin
      r  = a + b;
      of = (a[15] == b[15]) && (r[15] != a[15]);
    end else if (op[4]) begin
      r  = a - b;
      of = (a[15] != b[15]) && (r[15] != a[15]);
    end else if (op[5]) r = a ^ b;
    else if (op[6]) r = a << b[3:0];
    else if (op[7]) r = a >> b[3:0];
    return {1'b0, of, r[15], (r == 16'h0000), (a > b), (a == b), r};
  endfunction

  // SETTLE = 1 instance
  logic        rst, in_valid, in_ready, wb_valid, wb_ready, wb_we, illegal;
  logic [3:0]  opcode;
  logic [15:0] src_a, src_b, alu_a, alu_b, alu_result, wb_data;
  logic [2:0]  dst, wb_dst;
  logic [8:0]  alu_op;
  logic [5:0]  alu_flags, flags_q;

  assign {alu_flags, alu_result} = alu_model(alu_a, alu_b, alu_op);

  alu_sequencer #(.SETTLE(1), .DST_W(3)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .opcode(opcode),
    .src_a(src_a), .src_b(src_b), .dst(dst), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_result(alu_result), .alu_flags(alu_flags), .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_data(wb_data), .wb_dst(wb_dst), .wb_we(wb_we), .flags_q(flags_q), .illegal(illegal)
  );

  // SETTLE = 3 instance
  logic        rst_3, in_valid_3, in_ready_3, wb_valid_3, wb_ready_3, wb_we_3, illegal_3;
  logic [3:0]  opcode_3;
  logic [15:0] src_a_3, src_b_3, alu_a_3, alu_b_3, alu_result_3, wb_data_3;
  logic [2:0]  dst_3, wb_dst_3;
  logic [8:0]  alu_op_3;
  logic [5:0]  alu_flags_3, flags_q_3;

  assign {alu_flags_3, alu_result_3} = alu_model(alu_a_3, alu_b_3, alu_op_3);

  alu_sequencer #(.SETTLE(3), .DST_W(3)) dut3 (
    .clk(clk), .rst(rst_3), .in_valid(in_valid_3), .in_ready(in_ready_3), .opcode(opcode_3),
    .src_a(src_a_3), .src_b(src_b_3), .dst(dst_3), .alu_a(alu_a_3), .alu_b(alu_b_3),
    .alu_op(alu_op_3), .alu_result(alu_result_3), .alu_flags(alu_flags_3),
    .wb_valid(wb_valid_3), .wb_ready(wb_ready_3), .wb_data(wb_data_3), .wb_dst(wb_dst_3),
    .wb_we(wb_we_3), .flags_q(flags_q_3), .illegal(illegal_3)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Presents a request on dut1, waits (bounded) for acceptance, returns just after the accept edge.
  task automatic send(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                      input logic [2:0] d);
    int n;
    opcode   = op;
    src_a    = a;
    src_b    = b;
    dst      = d;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    check("accept_in_time", (n < 20), 1'b1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_wb;
    int n;
    n = 0;
    while (!wb_valid && n < 20) begin
      tick();
      n++;
    end
    check("wb_in_time", (n < 20), 1'b1);
  endtask

  task automatic pop;
    wb_ready = 1'b1;
    tick();
    wb_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; wb_ready = 1'b0; opcode = 4'd0;
    src_a = 16'h0; src_b = 16'h0; dst = 3'd0;
    rst_3 = 1'b1; in_valid_3 = 1'b0; wb_ready_3 = 1'b0; opcode_3 = 4'd0;
    src_a_3 = 16'h0; src_b_3 = 16'h0; dst_3 = 3'd0;
    tick();
    tick();
    rst = 1'b0;
    rst_3 = 1'b0;

    // Reset state
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_wb_valid", wb_valid, 1'b0);
    check("rst_wb_data", wb_data, 16'h0000);
    check("rst_wb_dst", wb_dst, 3'd0);
    check("rst_wb_we", wb_we, 1'b0);
    check("rst_flags", flags_q, 6'b000000);
    check("rst_illegal", illegal, 1'b0);
    check("rst_alu_a", alu_a, 16'h0000);
    check("rst_alu_b", alu_b, 16'h0000);
    check("rst_alu_op", alu_op, 9'b000000001);

    // 1: ADD 0x00FF + 0x0001 -> dst 3, one-cycle latency
    send(4'd3, 16'h00FF, 16'h0001, 3'd3);
    check("add_alu_op", alu_op, 9'b000001000);
    check("add_alu_a", alu_a, 16'h00FF);
    check("add_busy_ready", in_ready, 1'b0);
    check("add_no_wb_yet", wb_valid, 1'b0);
    tick();
    check("add_wb_valid", wb_valid, 1'b1);
    check("add_wb_data", wb_data, 16'h0100);
    check("add_wb_dst", wb_dst, 3'd3);
    check("add_wb_we", wb_we, 1'b1);
    check("add_flags", flags_q, 6'b000000);
    pop();
    check("add_idle_valid", wb_valid, 1'b0);
    check("add_idle_ready", in_ready, 1'b1);

    // 2: ADD to zero sets ZF, then CMP 5 vs 3
    send(4'd3, 16'hFFFF, 16'h0001, 3'd1);
    wait_wb();
    check("zero_wb_data", wb_data, 16'h0000);
    check("zero_flags", flags_q, 6'b000100);
    pop();
    send(4'd8, 16'h0005, 16'h0003, 3'd2);
    wait_wb();
    check("cmp_flags", flags_q, 6'b000110);
    check("cmp_wb_we", wb_we, 1'b0);
    pop();

    // 3: SUB 3 - 5
    send(4'd4, 16'h0003, 16'h0005, 3'd4);
    wait_wb();
    check("sub_wb_data", wb_data, 16'hFFFE);
    check("sub_wb_we", wb_we, 1'b1);
    check("sub_flags", flags_q, 6'b001010);
    pop();

    // 4: backpressure with a second request waiting
    send(4'd3, 16'h1234, 16'h0001, 3'd5);
    wait_wb();
    opcode = 4'd5; src_a = 16'h00F0; src_b = 16'h0F0F; dst = 3'd6; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("bp_wb_valid", wb_valid, 1'b1);
      check("bp_wb_data", wb_data, 16'h1235);
      check("bp_wb_dst", wb_dst, 3'd5);
      check("bp_in_ready", in_ready, 1'b0);
      tick();
    end
    wb_ready = 1'b1;
    #1;
    check("bp_ready_follows", in_ready, 1'b1);
    tick();
    wb_ready = 1'b0;
    in_valid = 1'b0;
    check("bp_valid_drop", wb_valid, 1'b0);
    check("bp_xor_issued", alu_op, 9'b000100000);
    wait_wb();
    check("xor_wb_data", wb_data, 16'h0FFF);
    check("xor_wb_dst", wb_dst, 3'd6);
    check("xor_flags", flags_q, 6'b001010);
    pop();

    // 5: illegal opcode 0xC
    send(4'hC, 16'h1111, 16'h2222, 3'd7);
    check("ill_pulse", illegal, 1'b1);
    check("ill_wb_valid", wb_valid, 1'b1);
    check("ill_wb_we", wb_we, 1'b0);
    check("ill_wb_data", wb_data, 16'h0000);
    check("ill_wb_dst", wb_dst, 3'd7);
    check("ill_flags", flags_q, 6'b001010);
    check("ill_alu_op", alu_op, 9'b000100000);
    tick();
    check("ill_pulse_end", illegal, 1'b0);
    pop();
    check("ill_idle", wb_valid, 1'b0);

    // 6: SETTLE = 3 latency, then reset during the second EXEC cycle
    opcode_3 = 4'd3; src_a_3 = 16'hFFFF; src_b_3 = 16'h0001; dst_3 = 3'd2; in_valid_3 = 1'b1;
    check("s3_ready", in_ready_3, 1'b1);
    tick();
    in_valid_3 = 1'b0;
    tick();
    check("s3_exec1", wb_valid_3, 1'b0);
    tick();
    check("s3_exec2", wb_valid_3, 1'b0);
    tick();
    check("s3_wb_valid", wb_valid_3, 1'b1);
    check("s3_wb_data", wb_data_3, 16'h0000);
    check("s3_flags", flags_q_3, 6'b000100);
    wb_ready_3 = 1'b1;
    tick();
    wb_ready_3 = 1'b0;
    opcode_3 = 4'd3; src_a_3 = 16'h0001; src_b_3 = 16'h0002; dst_3 = 3'd4; in_valid_3 = 1'b1;
    tick();
    in_valid_3 = 1'b0;
    tick();
    rst_3 = 1'b1;
    tick();
    rst_3 = 1'b0;
    check("s3_rst_valid", wb_valid_3, 1'b0);
    check("s3_rst_flags", flags_q_3, 6'b000000);
    check("s3_rst_ready", in_ready_3, 1'b1);
    check("s3_rst_alu_op", alu_op_3, 9'b000000001);
    for (int i = 0; i < 6; i++) begin
      tick();
      check("s3_no_beat", wb_valid_3, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Issue/writeback stage wrapped around the combinational 16-bit ALU controller.
- Accepts one instruction per handshake: a 4-bit opcode, two 16-bit operands and a destination index.
- Decodes the opcode to the ALU's 9-bit one-hot opFlag and holds operands stable for a configurable settle time.
- Captures the ALU result and flags, keeps the architectural 6-bit flags register, and presents a writeback beat with valid/ready.

Parameters:
- SETTLE, 1, number of EXEC cycles operands are held before capture; legal range 1..7.
- DST_W, 3, destination register index width.

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous reset, active-high
- in_valid  in  1  request valid
- in_ready  out  1  request accepted when in_valid & in_ready
- opcode  in  4  0 NOT, 1 OR, 2 AND, 3 ADD, 4 SUB, 5 XOR, 6 LSH, 7 RSH, 8 CMP, 9..15 illegal
- src_a  in  16  operand 1
- src_b  in  16  operand 2
- dst  in  DST_W  destination register index
- alu_a  out  16  to ALU val1
- alu_b  out  16  to ALU val2
- alu_op  out  9  to ALU opFlag, one-hot
- alu_result  in  16  from ALU output3
- alu_flags  in  6  from ALU flags: [0] EQ, [1] BG, [2] ZF, [3] SF, [4] OF, [5] unused
- wb_valid  out  1  writeback beat valid
- wb_ready  in  1  writeback consumer ready
- wb_data  out  16  captured result
- wb_dst  out  DST_W  captured destination
- wb_we  out  1  1 = register write; 0 for CMP and illegal opcodes
- flags_q  out  6  architectural flags register
- illegal  out  1  one-cycle pulse when an illegal opcode is accepted

Behaviour:
- Reset values (synchronous, rst high at an edge):
  - State = IDLE.
  - in_ready = 1 after reset.
  - wb_valid = 0; wb_data = 0; wb_dst = 0; wb_we = 0.
  - flags_q = 0; illegal = 0.
  - alu_a = 0; alu_b = 0; alu_op = 9'b000000001.
  - Settle counter = 0.
- FSM states: IDLE, EXEC, WB.
- IDLE:
  - in_ready = 1.
  - On accept of a legal opcode: register src_a/src_b onto alu_a/alu_b, the decoded one-hot onto alu_op, and dst; load counter = SETTLE-1; go to EXEC.
  - On accept of an illegal opcode: no ALU issue (alu_op stays at its current value); illegal = 1 for one cycle; load wb_data = 0, wb_we = 0, wb_dst = dst; go to WB.
- EXEC:
  - in_ready = 0; alu_* held constant.
  - Counter decrements each cycle.
  - At the edge where counter == 0:
    - Capture wb_data = alu_result; wb_we = (op != CMP).
    - Update flags_q (see flag-update rules).
    - Go to WB.
- WB:
  - wb_valid = 1; wb_data, wb_dst and wb_we held stable while wb_ready = 0.
  - On wb_valid & wb_ready: if in_valid is also high that cycle, accept the new request directly (in_ready = wb_ready in WB), go to EXEC or WB per the IDLE rules, and drop wb_valid for at least one cycle. Otherwise go to IDLE.
- Latency, SETTLE = 1: accept at edge N, capture at edge N+1, wb_valid high from N+1.
  - Minimum issue interval = SETTLE+1 cycles.
- Flag-update rules (bits not listed hold their value):
  - CMP: bits [1:0] from alu_flags.
  - SUB: bits [4:2] from alu_flags.
  - Every other legal op: bits [4] and [2].
  - Bit [5] is always 0.
  - Illegal opcodes: flags_q unchanged.
- Datapath: no arithmetic in this block; alu_result is passed through unmodified at 16 bits.
- Reset mid-operation: any in-flight or pending writeback is discarded, and the reset values apply on the next cycle.
- rst has priority over every handshake event in the same cycle.

Test Plan:
1. ADD, src_a = 0x00FF, src_b = 0x0001, dst = 3, SETTLE = 1 -> alu_op = 9'b000001000 the cycle after accept; wb_valid high from accept+1; wb_data = 0x0100; wb_dst = 3; wb_we = 1; flags_q[2] = 0 and flags_q[4] = 0.
2. CMP 0x0005 vs 0x0003 after a prior ADD that left ZF = 1 -> flags_q[1:0] = 2'b10; flags_q[2] still 1; wb_we = 0.
3. SUB 0x0003 - 0x0005 -> flags_q[3] = 1; wb_data equals the ALU output bit-exact; flags_q[1:0] unchanged from the previous CMP.
4. Backpressure: wb_ready = 0 for 5 cycles with in_valid held high -> wb_data/wb_dst stable and in_ready = 0 throughout; the second request is accepted in the same cycle wb_ready rises; wb_valid is low the following cycle.
5. opcode = 0xC -> illegal pulses for exactly 1 cycle; WB beat has wb_we = 0 and wb_data = 0; flags_q unchanged; alu_op unchanged.
6. SETTLE = 3, rst asserted during the second EXEC cycle -> next cycle: state IDLE, wb_valid = 0, flags_q = 0, in_ready = 1; no writeback beat is ever presented.
